// File: rtl/uart_inst_loader.sv
// Purpose : UART (8N1) program loader; frames a count-prefixed image into 32-bit
//           little-endian words and writes them to instruction memory, then starts the CPU.
// Latency : write strobe 1 clk after the 4th byte of a word; start 1 clk after the last write.
// Backpressure: none; the memory write port must accept one word per strobe.
//
// Ports:
//   clk          CPU clock (rising edge)
//   reset        asynchronous active-high reset
//   rx           UART receive line, idle high, asynchronous to clk
//   inst_wr_addr byte address of the current instruction-memory write
//   inst_wr_data assembled instruction word
//   inst_wr_en   one-cycle write strobe per word
//   start        one-cycle pulse after a complete, valid load
//   busy         high while a packet is in progress
//   frame_err    sticky bad-stop-bit flag, cleared at the next packet's first start bit
//   cksum_err    (LOADER_CHECKSUM_EN only) sticky payload checksum mismatch flag
//
// Optional feature macro: LOADER_CHECKSUM_EN appends an XOR checksum byte to each packet.
module uart_inst_loader #(
  parameter int          CLKS_PER_BIT = 52,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          TIMEOUT_CLKS = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] inst_wr_addr,
  output logic [31:0] inst_wr_data,
  output logic        inst_wr_en,
  output logic        start,
  output logic        busy,
  output logic        frame_err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic        cksum_err
`endif
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

  // ---------------- RX bit engine ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t   rx_state, rx_state_n;
  logic        rx_s1, rx_s2, rx_q;
  logic [CW-1:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  byte_dat;
  logic        byte_vld;
  logic        rx_fall, half_tick, bit_tick;
  logic        start_ok, stop_ok, stop_bad;

  assign rx_fall   = rx_q & ~rx_s2;
  assign half_tick = (clk_cnt == CW'(CLKS_PER_BIT/2 - 1));
  assign bit_tick  = (clk_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    rx_state_n = rx_state;
    start_ok   = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
      RX_START: if (half_tick) begin
                  if (rx_s2) rx_state_n = RX_IDLE;   // false start
                  else begin
                    rx_state_n = RX_DATA;
                    start_ok   = 1'b1;
                  end
                end
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_state_n = RX_STOP;
      RX_STOP:  if (bit_tick) begin
                  rx_state_n = RX_IDLE;
                  stop_ok    = rx_s2;
                  stop_bad   = ~rx_s2;
                end
      default:  rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_q     <= 1'b1;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      byte_dat <= '0;
      byte_vld <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_q     <= rx_s2;
      rx_state <= rx_state_n;
      // Counter restarts on every state change and every data-bit sample point.
      if (rx_state == RX_IDLE || rx_state_n != rx_state || bit_tick) clk_cnt <= '0;
      else                                                           clk_cnt <= clk_cnt + CW'(1);
      if (start_ok) bit_idx <= '0;
      if (rx_state == RX_DATA && bit_tick) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      byte_vld <= stop_ok;
      if (stop_ok) byte_dat <= shreg;
    end
  end

  // ---------------- Packet loader ----------------
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {CNT_LO, CNT_HI, LOAD, CHECK, DONE} ld_state_t;
  logic [7:0] cksum;
  logic       cksum_bad;
`else
  typedef enum logic [1:0] {CNT_LO, CNT_HI, LOAD, DONE} ld_state_t;
`endif

  ld_state_t   state, state_n;
  logic [7:0]  cnt_lo;
  logic [15:0] word_cnt, word_idx;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [TO_W-1:0] to_cnt;
  logic        counting, timeout_hit, do_write, abort;

`ifdef LOADER_CHECKSUM_EN
  assign counting = (state == CNT_HI) || (state == LOAD) || (state == CHECK);
`else
  assign counting = (state == CNT_HI) || (state == LOAD);
`endif
  assign timeout_hit = counting && !byte_vld && (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
  assign start       = (state == DONE);
  assign busy        = counting;

  always_comb begin
    state_n  = state;
    do_write = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    cksum_bad = 1'b0;
`endif
    case (state)
      CNT_LO: if (byte_vld) state_n = CNT_HI;
      CNT_HI: if (byte_vld) begin
`ifdef LOADER_CHECKSUM_EN
                if ({byte_dat, cnt_lo} == 16'd0) state_n = CHECK;
`else
                if ({byte_dat, cnt_lo} == 16'd0) state_n = DONE;
`endif
                else                             state_n = LOAD;
              end
      LOAD: begin
        if (byte_vld && lane == 2'd3) begin
          do_write = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          if (word_idx == word_cnt - 16'd1) state_n = CHECK;
`endif
        end
`ifndef LOADER_CHECKSUM_EN
        // Wait out the final write cycle so start never precedes the last store.
        if (inst_wr_en && word_idx == word_cnt) state_n = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (byte_vld) begin
               if (byte_dat == cksum) state_n = DONE;
               else                   cksum_bad = 1'b1;
             end
`endif
      DONE:    state_n = CNT_LO;
      default: state_n = CNT_LO;
    endcase
`ifdef LOADER_CHECKSUM_EN
    abort = stop_bad || timeout_hit || cksum_bad;
`else
    abort = stop_bad || timeout_hit;
`endif
    if (abort) state_n = CNT_LO;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CNT_LO;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_wr_addr <= '0;
      inst_wr_data <= '0;
      inst_wr_en   <= 1'b0;
      frame_err    <= 1'b0;
      cnt_lo       <= '0;
      word_cnt     <= '0;
      word_idx     <= '0;
      lane         <= '0;
      word_buf     <= '0;
      to_cnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
      cksum        <= '0;
      cksum_err    <= 1'b0;
`endif
    end else begin
      inst_wr_en <= do_write;
      if (do_write) begin
        inst_wr_data <= {byte_dat, word_buf};
        inst_wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
      end

      if (!counting || byte_vld) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TO_W'(1);

      if (state == CNT_LO && byte_vld) cnt_lo   <= byte_dat;
      if (state == CNT_HI && byte_vld) word_cnt <= {byte_dat, cnt_lo};

      // Per-packet accumulators are cleared while waiting for a new count and on abort,
      // which also drops any partially assembled word.
      if (state == CNT_LO || abort) begin
        word_idx <= '0;
        lane     <= '0;
        word_buf <= '0;
`ifdef LOADER_CHECKSUM_EN
        cksum    <= '0;
`endif
      end else if (state == LOAD && byte_vld) begin
        lane     <= lane + 2'd1;
        word_buf <= {byte_dat, word_buf[23:8]};
        if (do_write) word_idx <= word_idx + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        cksum    <= cksum ^ byte_dat;
`endif
      end

      // Sticky errors clear at a confirmed start bit that begins a new packet.
      if (stop_bad)                          frame_err <= 1'b1;
      else if (start_ok && state == CNT_LO)  frame_err <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (cksum_bad)                         cksum_err <= 1'b1;
      else if (start_ok && state == CNT_LO)  cksum_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Scoreboard bench for uart_inst_loader: stimulus pushes expected writes/starts,
// a negedge monitor pops and compares every inst_wr_en and start pulse.
module tb_uart_inst_loader;

  localparam int CPB = 8;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] inst_wr_addr, inst_wr_data;
  logic        inst_wr_en, start, busy, frame_err;
`ifdef LOADER_CHECKSUM_EN
  logic        cksum_err;
`endif

  uart_inst_loader #(.CLKS_PER_BIT(CPB), .BASE_ADDR(32'h0), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .inst_wr_addr(inst_wr_addr), .inst_wr_data(inst_wr_data), .inst_wr_en(inst_wr_en),
    .start(start), .busy(busy), .frame_err(frame_err)
`ifdef LOADER_CHECKSUM_EN
    , .cksum_err(cksum_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_start;
    logic [31:0] addr;
    logic [31:0] data;
    bit          after_wr;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  logic [31:0] pkt_w [0:3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.is_start = 1'b0; e.addr = a; e.data = d; e.after_wr = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_start(input bit after_wr);
    ev_t e;
    e.is_start = 1'b1; e.addr = '0; e.data = '0; e.after_wr = after_wr;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic prev_wr = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (inst_wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_wr", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wr_kind", {31'd0, e.is_start}, 32'd0);
          chk("wr_addr", inst_wr_addr, e.addr);
          chk("wr_data", inst_wr_data, e.data);
        end
      end
      if (start) begin
        if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("start_kind", {31'd0, e.is_start}, 32'd1);
          chk("start_after_wr", {31'd0, prev_wr}, {31'd0, e.after_wr});
          chk("busy_fall_at_start", {30'd0, prev_busy, busy}, 32'd2);
        end
      end
    end
    prev_wr   = inst_wr_en;
    prev_busy = busy;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; cyc(CPB);
    end
    rx = bad_stop ? 1'b0 : 1'b1; cyc(CPB);
    rx = 1'b1;
  endtask

  // Sends a complete packet of n words from pkt_w and queues the expected response.
  task automatic send_pkt(input int n);
    logic [7:0] ck;
    logic [31:0] w;
    ck = 8'h00;
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    for (int i = 0; i < n; i++) begin
      w = pkt_w[i];
      push_wr(32'(i * 4), w);
`ifdef LOADER_CHECKSUM_EN
      if (i == n - 1) push_start(1'b0);
`else
      if (i == n - 1) push_start(1'b1);
`endif
      for (int k = 0; k < 4; k++) begin
        send_byte(w[k*8 +: 8], 1'b0);
        ck = ck ^ w[k*8 +: 8];
      end
    end
    if (n == 0) push_start(1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck, 1'b0);
`endif
  endtask

  task automatic drain(input string nm);
    cyc(6);
    chk(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    cyc(3);
    chk("rst_addr", inst_wr_addr, 32'h0);
    chk("rst_data", inst_wr_data, 32'h0);
    chk("rst_wr_en", {31'd0, inst_wr_en}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    cyc(4);

    // Two-word program.
    pkt_w[0] = 32'h0000_0513;
    pkt_w[1] = 32'h0010_0093;
    send_pkt(2);
    drain("drain_n2");

    // Empty program: start only.
    send_pkt(0);
    drain("drain_n0");

    // Bad stop bit on 3rd payload byte.
    send_byte(8'h01, 1'b0);
    chk("busy_after_cnt0", {31'd0, busy}, 32'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b1);
    cyc(4);
    chk("frame_err_set", {31'd0, frame_err}, 32'd1);
    chk("busy_after_ferr", {31'd0, busy}, 32'd0);
    drain("drain_ferr");
    pkt_w[0] = 32'hDEAD_BEEF;
    send_pkt(1);
    chk("frame_err_clear", {31'd0, frame_err}, 32'd0);
    drain("drain_after_ferr");

    // Short glitch while idle.
    rx = 1'b0; cyc(CPB / 4);
    rx = 1'b1; cyc(4 * CPB);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_ferr", {31'd0, frame_err}, 32'd0);
    chk("glitch_addr", inst_wr_addr, 32'h0);
    chk("glitch_data", inst_wr_data, 32'hDEAD_BEEF);
    drain("drain_glitch");

    // Timeout mid-packet: N=3 but only 5 payload bytes.
    push_wr(32'h0, 32'h0403_0201);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
    chk("busy_before_tmo", {31'd0, busy}, 32'd1);
    cyc(TMO + 20);
    chk("busy_after_tmo", {31'd0, busy}, 32'd0);
    drain("drain_tmo");
    pkt_w[0] = 32'hCAFE_F00D;
    send_pkt(1);
    drain("drain_after_tmo");

    // Reset in the middle of a payload byte.
    push_wr(32'h0, 32'h4433_2211);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    rx = 1'b0; cyc(CPB);
    rx = 1'b1; cyc(3 * CPB);
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", inst_wr_addr, 32'h0);
    chk("mid_rst_data", inst_wr_data, 32'h0);
    chk("mid_rst_outs", {28'd0, inst_wr_en, start, busy, frame_err}, 32'd0);
    chk("mid_rst_queue", exp_q.size(), 32'd0);
    rx = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(2 * CPB);
    pkt_w[0] = 32'h1234_5678;
    pkt_w[1] = 32'h9ABC_DEF0;
    send_pkt(2);
    drain("drain_after_rst");

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: word is stored, no start, sticky error.
    push_wr(32'h0, 32'h0000_00AA);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h55, 1'b0);
    cyc(4);
    chk("cksum_err_set", {31'd0, cksum_err}, 32'd1);
    chk("cksum_busy", {31'd0, busy}, 32'd0);
    drain("drain_cksum");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
